// File: rtl/sdr_cfg_pkg.sv
// Shared constants and types for the SPI configuration register bank that steers the SDR core.
// The address map and reset values live here so the core and the bench agree on them.
package sdr_cfg_pkg;

    localparam logic [7:0]  ADDR_PHASE_INC    = 8'h00;
    localparam logic [7:0]  ADDR_GAIN         = 8'h01;
    localparam logic [7:0]  ADDR_CTRL         = 8'h02;
    localparam logic [7:0]  ADDR_ERR_CLR      = 8'h7F;

    localparam int          CTRL_PWM_EN       = 0;
    localparam int          CTRL_MUTE         = 1;
    localparam int          CTRL_COMP_INV     = 2;

    localparam logic [23:0] PHASE_INC_RST_DEF = 24'h0A3066;
    localparam logic [3:0]  GAIN_RST_DEF      = 4'd8;
    localparam logic [7:0]  CTRL_RST          = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Only the three defined control bits are writable; the reserved bits always read as 0.
    function automatic logic [7:0] ctrl_word(input logic [2:0] bits);
        logic [7:0] w;
        w                = '0;
        w[CTRL_PWM_EN]   = bits[0];
        w[CTRL_MUTE]     = bits[1];
        w[CTRL_COMP_INV] = bits[2];
        return w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection in the clk domain.
// STAGES must be at least 2.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_cfg_regs.sv
// SPI-slave (mode 0) write-frame decoder holding the NCO/gain/control registers, committed at frame end.
// Optional macro SPI_READBACK_EN adds a MISO port and read frames (address bit 7 set).
module spi_cfg_regs
    import sdr_cfg_pkg::*;
#(
    parameter int                ADDR_W        = 8,
    parameter int                DATA_W        = 24,
    parameter logic [DATA_W-1:0] PHASE_INC_RST = PHASE_INC_RST_DEF,
    parameter logic [3:0]        GAIN_RST      = GAIN_RST_DEF,
    parameter int                SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              RSTb,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              CS,
    output logic [DATA_W-1:0] phase_inc,
    output logic [3:0]        gain,
    output logic [7:0]        ctrl,
    output logic              cfg_update,
    output logic              frame_err
`ifdef SPI_READBACK_EN
    ,
    output logic              MISO
`endif
);

    localparam int               FRAME_W  = ADDR_W + DATA_W;
    localparam int               CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_s, cs_rise, cs_fall;

    cfg_state_e         state_q, state_d;
    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic               cs_fall_pend;
    logic               sck_take;

    logic               frame_ok;
    logic [ADDR_W-1:0]  frame_addr;
    logic [DATA_W-1:0]  frame_data;
    logic               wr_en, wr_phase, wr_gain, wr_ctrl, wr_err_clr, wr_any;

    // CS idles high, so its chain resets high to avoid a false frame start out of reset.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk (clk), .rst_n(RSTb), .din(SCK),  .dout(sck_s),  .rise(sck_rise),  .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst_n(RSTb), .din(MOSI), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk), .rst_n(RSTb), .din(CS),   .dout(cs_s),   .rise(cs_rise),   .fall(cs_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_s, sck_fall, mosi_rise, mosi_fall, cs_s};

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall || cs_fall_pend) state_d = SHIFT;
            SHIFT:   if (cs_rise)                 state_d = COMMIT;
            COMMIT:                               state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // A CS fall seen while committing is remembered so back-to-back frames are not dropped.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb)                             cs_fall_pend <= 1'b0;
        else if (state_q == COMMIT && cs_fall) cs_fall_pend <= 1'b1;
        else if (state_q == IDLE)              cs_fall_pend <= 1'b0;
    end

    assign sck_take   = (state_q == SHIFT) && sck_rise && !cs_rise;
    assign frame_ok   = (bit_cnt == CNT_FULL);
    assign frame_addr = shift_q[FRAME_W-1 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];

`ifdef SPI_READBACK_EN
    assign wr_en = (state_q == COMMIT) && frame_ok && !frame_addr[ADDR_W-1];
`else
    assign wr_en = (state_q == COMMIT) && frame_ok;
`endif

    assign wr_phase   = wr_en && (frame_addr == ADDR_W'(ADDR_PHASE_INC));
    assign wr_gain    = wr_en && (frame_addr == ADDR_W'(ADDR_GAIN));
    assign wr_ctrl    = wr_en && (frame_addr == ADDR_W'(ADDR_CTRL));
    assign wr_err_clr = wr_en && (frame_addr == ADDR_W'(ADDR_ERR_CLR));
    assign wr_any     = wr_phase | wr_gain | wr_ctrl | wr_err_clr;

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (state_q == IDLE) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (sck_take) begin
            shift_q <= {shift_q[FRAME_W-2:0], mosi_s};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // All registers and the update strobe change on the same edge, so the datapath sees whole words.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            phase_inc  <= PHASE_INC_RST;
            gain       <= GAIN_RST;
            ctrl       <= CTRL_RST;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_update <= wr_any;
            if (wr_phase)   phase_inc <= frame_data;
            if (wr_gain)    gain      <= frame_data[3:0];
            if (wr_ctrl)    ctrl      <= ctrl_word(frame_data[2:0]);
            if (wr_err_clr) frame_err <= 1'b0;
            if (state_q == COMMIT && !frame_ok) frame_err <= 1'b1;
        end
    end

`ifdef SPI_READBACK_EN
    logic               rd_active;
    logic [DATA_W-1:0]  rb_shift;
    logic [DATA_W-1:0]  rb_sel;
    logic [ADDR_W-1:0]  next_addr;

    // Address as it will stand once the bit arriving on this SCK rise is shifted in.
    assign next_addr = {shift_q[ADDR_W-2:0], mosi_s};

    always_comb begin
        rb_sel = '0;
        case ({1'b0, next_addr[ADDR_W-2:0]})
            ADDR_W'(ADDR_PHASE_INC): rb_sel = phase_inc;
            ADDR_W'(ADDR_GAIN):      rb_sel = DATA_W'(gain);
            ADDR_W'(ADDR_CTRL):      rb_sel = DATA_W'(ctrl);
            ADDR_W'(ADDR_ERR_CLR):   rb_sel = DATA_W'(frame_err);
            default:                 rb_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            rd_active <= 1'b0;
            rb_shift  <= '0;
        end else if (state_q == IDLE) begin
            rd_active <= 1'b0;
            rb_shift  <= '0;
        end else if (sck_take && bit_cnt == CNT_W'(ADDR_W - 1) && next_addr[ADDR_W-1]) begin
            rd_active <= 1'b1;
            rb_shift  <= rb_sel;
        end else if (state_q == SHIFT && sck_fall && rd_active && bit_cnt > CNT_W'(ADDR_W)) begin
            rb_shift  <= {rb_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign MISO = rd_active & ~cs_s & rb_shift[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Directed bench for spi_cfg_regs: SPI frames at SCK = clk/8, commits scored against an expected queue.
module tb_spi_cfg_regs;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 3;
    localparam int HALF_SCK    = 40;

    logic        clk  = 1'b0;
    logic        RSTb = 1'b0;
    logic        SCK  = 1'b0;
    logic        MOSI = 1'b0;
    logic        CS   = 1'b1;
    logic [23:0] phase_inc;
    logic [3:0]  gain;
    logic [7:0]  ctrl;
    logic        cfg_update;
    logic        frame_err;
`ifdef SPI_READBACK_EN
    logic        MISO;
`endif

    int          n_total   = 0;
    int          n_pass    = 0;
    int          pulse_cnt = 0;
    logic [35:0] exp_q[$];

    logic [23:0] m_phase;
    logic [3:0]  m_gain;
    logic [7:0]  m_ctrl;
    logic        m_err;

    spi_cfg_regs #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .RSTb      (RSTb),
        .SCK       (SCK),
        .MOSI      (MOSI),
        .CS        (CS),
        .phase_inc (phase_inc),
        .gain      (gain),
        .ctrl      (ctrl),
        .cfg_update(cfg_update),
        .frame_err (frame_err)
`ifdef SPI_READBACK_EN
        ,
        .MISO      (MISO)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [35:0] cur_regs();
        return {phase_inc, gain, ctrl};
    endfunction

    function automatic logic [35:0] model_regs();
        return {m_phase, m_gain, m_ctrl};
    endfunction

    task automatic model_reset();
        m_phase = 24'h0A3066;
        m_gain  = 4'd8;
        m_ctrl  = 8'h01;
        m_err   = 1'b0;
    endtask

    // Scoreboard: every commit strobe pops the register image expected for that frame.
    always @(negedge clk) begin
        if (RSTb && cfg_update === 1'b1) begin
            pulse_cnt++;
            check("sb_pulse_expected", 36'(exp_q.size() != 0), 36'd1);
            if (exp_q.size() != 0) check("sb_regs", cur_regs(), exp_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic shift_bits(input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = val[i];
            #HALF_SCK SCK = 1'b1;
            #HALF_SCK SCK = 1'b0;
        end
    endtask

    task automatic frame(input logic [63:0] val, input int n);
        @(negedge clk);
        CS = 1'b0;
        #HALF_SCK;
        shift_bits(val, n);
        #HALF_SCK;
        CS = 1'b1;
    endtask

    // Updates the model, pushes the expected image for mapped addresses and checks latency.
    task automatic write_frame(input string tag, input logic [7:0] addr, input logic [23:0] data);
        bit commit;
        bit seen;
        int p0;
        commit = 1'b0;
        case (addr)
            8'h00:   begin m_phase = data;                commit = 1'b1; end
            8'h01:   begin m_gain  = data[3:0];           commit = 1'b1; end
            8'h02:   begin m_ctrl  = {5'b0, data[2:0]};   commit = 1'b1; end
            8'h7F:   begin m_err   = 1'b0;                commit = 1'b1; end
            default: ;
        endcase
        if (commit) exp_q.push_back(model_regs());
        p0 = pulse_cnt;
        frame({32'h0, addr, data}, 32);
        seen = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk); #1;
            if (cfg_update === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_pulse_in_window"}, 36'(seen), 36'(commit));
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_pulse_count"}, 36'(pulse_cnt - p0), 36'(commit));
        check({tag, "_regs"}, cur_regs(), model_regs());
        check({tag, "_frame_err"}, 36'(frame_err), 36'(m_err));
    endtask

    task automatic err_frame(input string tag, input logic [63:0] val, input int n);
        int p0;
        p0 = pulse_cnt;
        frame(val, n);
        repeat (LAT + 4) @(posedge clk);
        #1;
        m_err = 1'b1;
        check({tag, "_pulse_count"}, 36'(pulse_cnt - p0), 36'd0);
        check({tag, "_regs"}, cur_regs(), model_regs());
        check({tag, "_frame_err"}, 36'(frame_err), 36'(m_err));
    endtask

    // ---------------- directed sequence ----------------
    int          p0;
    logic [23:0] rx;
    logic [31:0] rd_word;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_regs", cur_regs(), {24'h0A3066, 4'd8, 8'h01});
        check("rst_cfg_update", 36'(cfg_update), 36'd0);
        check("rst_frame_err", 36'(frame_err), 36'd0);
        @(negedge clk) RSTb = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("idle_regs", cur_regs(), model_regs());
        check("idle_no_pulse", 36'(pulse_cnt), 36'd0);

        write_frame("wr_phase", 8'h00, 24'h0B71B0);
        write_frame("wr_ctrl", 8'h02, 24'h000006);
        write_frame("wr_ctrl_mask", 8'h02, 24'hFFFFFD);
        write_frame("unmapped_05", 8'h05, 24'h123456);
        write_frame("unmapped_c3", 8'hC3, 24'h00000F);

        err_frame("short31", 64'h0123_4567, 31);
        err_frame("long33", 64'h1_0000_0003, 33);
        write_frame("err_clr", 8'h7F, 24'h000000);
        err_frame("cs_glitch", 64'h0, 0);
        write_frame("err_clr2", 8'h7F, 24'hABCDEF);

        // SCK activity with CS high must not disturb the next frame.
        for (int i = 0; i < 12; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            #20 SCK = 1'b1;
            #20 SCK = 1'b0;
        end
        write_frame("gain_after_noise", 8'h01, 24'hFFFFF3);

        for (int i = 0; i < 4; i++)
            write_frame("rand", 8'($urandom_range(0, 2)), 24'($urandom));

        // Second frame starts while the first is committing.
        m_gain  = 4'hA;
        exp_q.push_back(model_regs());
        m_phase = 24'h00ABCD;
        exp_q.push_back(model_regs());
        p0 = pulse_cnt;
        @(negedge clk);
        CS = 1'b0;
        #HALF_SCK;
        shift_bits({32'h0, 8'h01, 24'h00000A}, 32);
        #HALF_SCK;
        CS = 1'b1;
        #10;
        CS = 1'b0;
        #HALF_SCK;
        shift_bits({32'h0, 8'h00, 24'h00ABCD}, 32);
        #HALF_SCK;
        CS = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        check("b2b_pulse_count", 36'(pulse_cnt - p0), 36'd2);
        check("b2b_regs", cur_regs(), model_regs());
        check("b2b_frame_err", 36'(frame_err), 36'd0);

        // Reset in the middle of a frame.
        err_frame("pre_reset_short", 64'h1234, 16);
        @(negedge clk);
        CS = 1'b0;
        #HALF_SCK;
        shift_bits(64'($urandom), 16);
        RSTb = 1'b0;
        #1;
        check("rst_mid_regs", cur_regs(), {24'h0A3066, 4'd8, 8'h01});
        check("rst_mid_cfg_update", 36'(cfg_update), 36'd0);
        check("rst_mid_frame_err", 36'(frame_err), 36'd0);
        CS = 1'b1;
        repeat (4) @(negedge clk);
        RSTb = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        write_frame("gain5", 8'h01, 24'h000005);
        check("gain5_value", 36'(gain), 36'd5);

`ifdef SPI_READBACK_EN
        write_frame("rb_wr", 8'h00, 24'h123456);
        rx      = '0;
        rd_word = {8'h80, 24'h000000};
        p0      = pulse_cnt;
        @(negedge clk);
        CS = 1'b0;
        #HALF_SCK;
        for (int i = 31; i >= 0; i--) begin
            MOSI = rd_word[i];
            #(HALF_SCK - 1);
            if (i < 24) rx = {rx[22:0], MISO};
            #1 SCK = 1'b1;
            #HALF_SCK SCK = 1'b0;
        end
        #HALF_SCK;
        CS = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("rb_data", 36'(rx), 36'h123456);
        check("rb_no_write", cur_regs(), model_regs());
        check("rb_no_pulse", 36'(pulse_cnt - p0), 36'd0);
        check("rb_miso_idle", 36'(MISO), 36'd0);
        check("rb_frame_err", 36'(frame_err), 36'd0);
`endif

        repeat (20) @(posedge clk);
        #1;
        check("sb_queue_empty", 36'(exp_q.size()), 36'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
